// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants for the control sequencer.
//   - state encodings (IDLE=0000, T0..T5=0001..0110, HALT=1111)
//   - 5-bit opcode constants and IR field bit positions
//   - one-hot ALU op bit indices and the decoder result struct
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0000,
    ST_T0   = 4'b0001,
    ST_T1   = 4'b0010,
    ST_T2   = 4'b0011,
    ST_T3   = 4'b0100,
    ST_T4   = 4'b0101,
    ST_T5   = 4'b0110,
    ST_HALT = 4'b1111
  } state_t;

  localparam logic [4:0] OPC_NOT  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_SUB  = 5'b00101;
  localparam logic [4:0] OPC_AND  = 5'b00110;
  localparam logic [4:0] OPC_OR   = 5'b00111;
  localparam logic [4:0] OPC_NEG  = 5'b01000;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  // IR fields: opcode, then Ra/Rb/Rc register selects
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // bit positions inside the one-hot op vector
  localparam int OP_ADD = 5;
  localparam int OP_SUB = 4;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 2;
  localparam int OP_NEG = 1;
  localparam int OP_NOT = 0;

  typedef struct packed {
    logic [5:0] op;
    logic       is_unary;
    logic       is_halt;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bundle of sequencer inputs and control outputs.
//   master: drives Start/IR/MemRdy, observes strobes and status
//   slave : the sequencer side
interface control_sequencer_if;
  logic        Start;
  logic [31:0] IR;
  logic        MemRdy;
  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic Gra, Grb, Grc, Rin, Rout;
  logic ADD, SUB, AND, OR, NEG, NOT;
  logic       Run;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    output Start, IR, MemRdy,
    input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
    input  Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR, NEG, NOT,
    input  Run, Illegal, State
  );

  modport slave (
    input  Start, IR, MemRdy,
    output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
    output Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR, NEG, NOT,
    output Run, Illegal, State
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// opcode_decode: combinational opcode classifier.
//   opcode in 5  : IR[31:27] as captured by the sequencer
//   dec    out   : {one-hot ALU op, is_unary, is_halt, is_illegal}
module opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output dec_t       dec
);
  always_comb begin
    dec = '0;
    case (opcode)
      OPC_ADD:  dec.op[OP_ADD] = 1'b1;
      OPC_SUB:  dec.op[OP_SUB] = 1'b1;
      OPC_AND:  dec.op[OP_AND] = 1'b1;
      OPC_OR:   dec.op[OP_OR]  = 1'b1;
      OPC_NOT:  begin dec.op[OP_NOT] = 1'b1; dec.is_unary = 1'b1; end
      OPC_NEG:  begin dec.op[OP_NEG] = 1'b1; dec.is_unary = 1'b1; end
      OPC_HALT: dec.is_halt = 1'b1;
      default:  dec.is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM (fetch T0..T2, execute T3..T5).
//   Clock in 1 : rising-edge clock
//   Clear in 1 : synchronous active-high reset, forces IDLE from anywhere
//   bus        : control_sequencer_if.slave (Start/IR/MemRdy in, strobes out)
// Build option CTRL_ILLEGAL_TRAP_EN: undefined opcodes trap to HALT with
// Illegal=1; otherwise they execute as a NOP and Illegal stays 0.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic Clock,
  input logic Clear,
  control_sequencer_if.slave bus
);
  state_t     state;
  logic [4:0] opcode_q;
  dec_t       dec;

  // only the opcode field steers the sequencer; register selects go to the
  // register file via Gra/Grb/Grc
  logic unused_ir;
  assign unused_ir = ^bus.IR[RA_MSB:0];

  opcode_decode u_dec (.opcode(opcode_q), .dec(dec));

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state    <= ST_IDLE;
      opcode_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.Start) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   if (bus.MemRdy) state <= ST_T2;
        ST_T2: begin
          state    <= ST_T3;
          opcode_q <= bus.IR[OPC_MSB:OPC_LSB];
        end
        ST_T3: begin
          if (dec.is_halt)         state <= ST_HALT;
          else if (dec.is_illegal)
`ifdef CTRL_ILLEGAL_TRAP_EN
                                   state <= ST_HALT;
`else
                                   state <= ST_T0;
`endif
          else                     state <= ST_T4;
        end
        ST_T4:   state <= dec.is_unary ? ST_T0 : ST_T5;
        ST_T5:   state <= ST_T0;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // execute-phase classes of the held opcode
  logic binop, unop;
  assign binop = (|dec.op) & ~dec.is_unary;
  assign unop  = (|dec.op) &  dec.is_unary;

  logic [5:0] op_out;

  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0; bus.MARin = 1'b0;
    bus.Zin   = 1'b0; bus.PCin    = 1'b0; bus.MDRin  = 1'b0; bus.IRin  = 1'b0;
    bus.Yin   = 1'b0; bus.IncPC   = 1'b0; bus.Read   = 1'b0;
    bus.Gra   = 1'b0; bus.Grb     = 1'b0; bus.Grc    = 1'b0;
    bus.Rin   = 1'b0; bus.Rout    = 1'b0;
    op_out    = '0;
    case (state)
      ST_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      ST_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
      ST_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      ST_T3: begin
        if (binop) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (unop) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; op_out = dec.op;
        end
      end
      ST_T4: begin
        if (binop) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; op_out = dec.op;
        end else if (unop) begin
          bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
        end
      end
      ST_T5: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
      default: ;
    endcase
  end

  assign bus.ADD   = op_out[OP_ADD];
  assign bus.SUB   = op_out[OP_SUB];
  assign bus.AND   = op_out[OP_AND];
  assign bus.OR    = op_out[OP_OR];
  assign bus.NEG   = op_out[OP_NEG];
  assign bus.NOT   = op_out[OP_NOT];
  assign bus.Run   = (state != ST_IDLE) && (state != ST_HALT);
  assign bus.State = state;
`ifdef CTRL_ILLEGAL_TRAP_EN
  // the trapping opcode stays in opcode_q, so HALT plus an illegal code
  // is exactly the sticky trap condition
  assign bus.Illegal = (state == ST_HALT) && dec.is_illegal;
`else
  assign bus.Illegal = 1'b0;
`endif
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports, clock and reset first: Clock in 1 system clock, rising edge; Clear in 1 reset.
REQ-002 SHALL state the decided clocking exactly: one clock; reset is synchronous and active-high (Clock, Clear).
REQ-003 Inputs: Start in 1 leave IDLE; IR in 32 instruction register contents; MemRdy in 1 memory read data valid.
REQ-004 Datapath strobe outputs, 1 bit each: PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read.
REQ-005 Register-file outputs, 1 bit each: Gra, Grb, Grc (select IR field Ra/Rb/Rc), Rin, Rout.
REQ-006 ALU op outputs, 1 bit each, one-hot or all-zero: ADD, SUB, AND, OR, NEG, NOT.
REQ-007 Status outputs: Run out 1 (high in any non-IDLE, non-HALT state); Illegal out 1; State out 4 (debug copy of state register).

Function
REQ-008 Opcode SHALL be IR[31:27]: NOT=00011, ADD=00100, SUB=00101, AND=00110, OR=00111, NEG=01000, HALT=11011; all other codes are undefined.
REQ-009 Outputs SHALL be a Moore decode of the state register; no output depends combinationally on IR, MemRdy or Start.
REQ-010 States: IDLE, T0, T1, T2, T3, T4, T5, HALT. A strobe not listed for a state SHALL be 0 in that state.
REQ-011 IDLE: all strobes 0; go to T0 on the edge where Start=1.
REQ-012 T0: PCout, MARin, IncPC, Zin; go to T1.
REQ-013 T1: Zlowout, PCin, Read, MDRin; stay in T1 while MemRdy=0 with all four held; go to T2 on the edge where MemRdy=1.
REQ-014 T2: MDRout, IRin; go to T3. IR SHALL be decoded on the T2->T3 edge and held in an internal opcode register.
REQ-015 Two-operand ops (ADD/SUB/AND/OR): T3 Grb, Rout, Yin; T4 Grc, Rout, op, Zin; T5 Zlowout, Gra, Rin; then T0.
REQ-016 One-operand ops (NOT/NEG): T3 Grb, Rout, op, Zin; T4 Zlowout, Gra, Rin; then T0. T5 SHALL be skipped.
REQ-017 HALT opcode: T3 asserts no strobes, then HALT. HALT holds all strobes 0 and Run=0 until Clear; Start is ignored in HALT.
REQ-018 Latency with MemRdy tied 1: 6 cycles T0..T5 for two-operand ops, 5 cycles for one-operand ops; each T1 wait cycle adds 1.
REQ-019 At most one ALU op output SHALL be high in any cycle.
REQ-020 Start=1 while the sequencer is not in IDLE SHALL have no effect.

Reset
REQ-021 Clear=1 at a rising edge SHALL force IDLE from any state, including T1 with MemRdy=0 and HALT.
REQ-022 While in reset and in the cycle after it, all strobes, Run and Illegal SHALL be 0, State=0000, and the opcode register SHALL be 0.
REQ-023 A Clear pulse takes priority over simultaneous Start or MemRdy.

Configuration
REQ-024 The macro CTRL_ILLEGAL_TRAP_EN SHALL select the handling of undefined opcodes.
REQ-025 With CTRL_ILLEGAL_TRAP_EN defined: an undefined opcode goes T3->HALT and sets Illegal=1, held until Clear.
REQ-026 Without CTRL_ILLEGAL_TRAP_EN: an undefined opcode is a NOP (T3 with no strobes, then T0), and Illegal is tied to 0.

Structure
REQ-027 Package cpu_ctrl_pkg SHALL hold the opcode constants, state encodings (IDLE=0000, T0..T5=0001..0110, HALT=1111) and IR field bit positions.
REQ-028 Sub-module opcode_decode (combinational) SHALL map the 5-bit opcode to {one-hot op, is_unary, is_halt, is_illegal}.
REQ-029 The sequencer SHALL contain exactly one state register and one opcode register. No other storage is permitted.

Verification
REQ-030 Clear 2 cycles, Start=1, MemRdy=1, IR=0x1A920000 (NOT, Ra=R5, Rb=R2) -> T3 has Grb+Rout+NOT+Zin, T4 has Zlowout+Gra+Rin, T0 re-entered 5 cycles after the first T0.
REQ-031 IR=0x22000000 (ADD), MemRdy=1 -> Yin only in T3, ADD+Zin only in T4, Rin only in T5; 6-cycle loop.
REQ-032 MemRdy held 0 for 3 cycles in T1 -> T1 held 4 cycles with Read=MDRin=1 throughout; IRin pulses exactly once.
REQ-033 IR=0xD8000000 (HALT) -> HALT reached, Run=0; Start pulses ignored; Clear returns to IDLE.
REQ-034 IR=0xF8000000 (undefined) -> with CTRL_ILLEGAL_TRAP_EN: HALT and Illegal=1; without it: T0 re-entered, Illegal=0.
REQ-035 Clear asserted mid-T4 of SUB -> IDLE on the next edge, all strobes 0, no Rin pulse.
